drr_sched_weighted: RTL and testbench

Parametrised weighted deficit-round-robin scheduler, the next generation of the flow-level DRR arbiter in the packet scheduling path. It sits between the per-flow packet queues and the egress datapath. It sees each queue's head-of-line packet size and picks the next queue to pop. New behaviour in this generation:

- per-queue programmable quantum (weight);
- a registered valid/ready grant handshake with back-pressure;
- correct DRR deficit clearing when a queue empties;
- saturating deficit arithmetic;
- optional per-queue statistics.

---
 rtl/drr_sched_weighted.sv | 179 +++++++++++++++++
 tb/tb_drr_sched_weighted.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drr_sched_weighted.sv
// Weighted deficit-round-robin scheduler with registered valid/ready grant.
// Optional per-queue byte/packet statistics are built when DRR_STATS_EN is defined.
module drr_sched_weighted #(
  parameter int QUEUES    = 4,
  parameter int SIZE_W    = 16,
  parameter int QUANTUM_W = 12,
  parameter int DFT_W     = 20,
  localparam int IDX_W    = $clog2(QUEUES)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [QUEUES*SIZE_W-1:0]      size_i,
  input  logic [QUEUES-1:0]             size_val_i,
  input  logic [QUEUES*QUANTUM_W-1:0]   quantum_i,
  output logic                          grant_val_o,
  output logic [IDX_W-1:0]              grant_idx_o,
  output logic [SIZE_W-1:0]             grant_size_o,
  input  logic                          grant_rdy_i,
  input  logic [IDX_W-1:0]              stat_sel_i,
  input  logic                          stat_clr_i,
  output logic [31:0]                   stat_bytes_o,
  output logic [31:0]                   stat_pkts_o
);

  // state  | meaning
  // VISIT  | add quantum to queue p, or clear its deficit if empty
  // CHECK  | grant head of p if the deficit covers it, else move on
  // GRANT  | hold grant until handshake, then charge the deficit
  // SETTLE | idle cycle while upstream presents the new head
  typedef enum logic [1:0] {ST_VISIT, ST_CHECK, ST_GRANT, ST_SETTLE} state_t;

  localparam int MAX_IN = (SIZE_W > QUANTUM_W) ? SIZE_W : QUANTUM_W;
  localparam logic [IDX_W-1:0] P_LAST = IDX_W'(QUEUES - 1);

  if (DFT_W < MAX_IN + 1) begin : g_dft_w_check
    $error("drr_sched_weighted: DFT_W must be at least max(SIZE_W, QUANTUM_W)+1");
  end

  state_t              state_q, state_nxt;
  logic [IDX_W-1:0]    p_q, p_nxt;
  logic [DFT_W-1:0]    dft_q [QUEUES];
  logic                grant_val_q;
  logic [IDX_W-1:0]    grant_idx_q;
  logic [SIZE_W-1:0]   grant_size_q;

  logic                val_p;
  logic [SIZE_W-1:0]   size_p;
  logic [QUANTUM_W-1:0] quantum_p;
  logic [DFT_W-1:0]    dft_p;
  logic [DFT_W:0]      dft_sum;
  logic [DFT_W-1:0]    dft_sat;
  logic                hs;
  logic                p_adv, dft_clr, dft_add, dft_sub, grant_load;

  assign val_p     = size_val_i[p_q];
  assign size_p    = size_i[p_q*SIZE_W +: SIZE_W];
  assign quantum_p = quantum_i[p_q*QUANTUM_W +: QUANTUM_W];
  assign dft_p     = dft_q[p_q];
  assign dft_sum   = {1'b0, dft_p} + (DFT_W+1)'(quantum_p);
  assign dft_sat   = dft_sum[DFT_W] ? {DFT_W{1'b1}} : dft_sum[DFT_W-1:0];
  assign p_nxt     = (p_q == P_LAST) ? '0 : p_q + 1'b1;
  assign hs        = grant_val_q && grant_rdy_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_VISIT;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    p_adv      = 1'b0;
    dft_clr    = 1'b0;
    dft_add    = 1'b0;
    dft_sub    = 1'b0;
    grant_load = 1'b0;
    case (state_q)
      ST_VISIT: begin
        if (!val_p) begin
          dft_clr = 1'b1;
          p_adv   = 1'b1;
        end else begin
          dft_add   = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!val_p) begin
          dft_clr   = 1'b1;
          p_adv     = 1'b1;
          state_nxt = ST_VISIT;
        end else if (DFT_W'(size_p) <= dft_p) begin
          grant_load = 1'b1;
          state_nxt  = ST_GRANT;
        end else begin
          p_adv     = 1'b1;
          state_nxt = ST_VISIT;
        end
      end
      ST_GRANT: begin
        if (hs) begin
          dft_sub   = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: state_nxt = ST_CHECK;
      default:   state_nxt = ST_VISIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_q          <= '0;
      grant_val_q  <= 1'b0;
      grant_idx_q  <= '0;
      grant_size_q <= '0;
      for (int q = 0; q < QUEUES; q++) dft_q[q] <= '0;
    end else begin
      if (p_adv) p_q <= p_nxt;
      // p does not move during GRANT, so dft_q[p_q] is the granted queue
      if (dft_clr)      dft_q[p_q] <= '0;
      else if (dft_add) dft_q[p_q] <= dft_sat;
      else if (dft_sub) dft_q[p_q] <= dft_p - DFT_W'(grant_size_q);
      if (grant_load) begin
        grant_val_q  <= 1'b1;
        grant_idx_q  <= p_q;
        grant_size_q <= size_p;
      end else if (hs) begin
        grant_val_q <= 1'b0;
      end
    end
  end

  assign grant_val_o  = grant_val_q;
  assign grant_idx_o  = grant_idx_q;
  assign grant_size_o = grant_size_q;

`ifdef DRR_STATS_EN
  logic [31:0] bytes_q [QUEUES];
  logic [31:0] pkts_q  [QUEUES];
  logic [31:0] stat_bytes_q, stat_pkts_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int q = 0; q < QUEUES; q++) begin
        bytes_q[q] <= '0;
        pkts_q[q]  <= '0;
      end
      stat_bytes_q <= '0;
      stat_pkts_q  <= '0;
    end else begin
      if (stat_clr_i) begin
        for (int q = 0; q < QUEUES; q++) begin
          bytes_q[q] <= '0;
          pkts_q[q]  <= '0;
        end
      end else if (hs) begin
        bytes_q[grant_idx_q] <= bytes_q[grant_idx_q] + 32'(grant_size_q);
        pkts_q[grant_idx_q]  <= pkts_q[grant_idx_q] + 32'd1;
      end
      if (stat_clr_i || int'(stat_sel_i) >= QUEUES) begin
        stat_bytes_q <= '0;
        stat_pkts_q  <= '0;
      end else begin
        stat_bytes_q <= bytes_q[stat_sel_i];
        stat_pkts_q  <= pkts_q[stat_sel_i];
      end
    end
  end

  assign stat_bytes_o = stat_bytes_q;
  assign stat_pkts_o  = stat_pkts_q;
`else
  logic unused_stat;
  assign unused_stat  = ^{stat_sel_i, stat_clr_i};
  assign stat_bytes_o = '0;
  assign stat_pkts_o  = '0;
`endif

endmodule

// File: tb/tb_drr_sched_weighted.sv
// Directed bench for drr_sched_weighted: latency, deficit carry, weighting,
// back-pressure, empty clear, async reset and statistics.
module tb_drr_sched_weighted;

  localparam int QUEUES    = 4;
  localparam int SIZE_W    = 16;
  localparam int QUANTUM_W = 12;
  localparam int DFT_W     = 20;
  localparam int IDX_W     = 2;
`ifdef DRR_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic                        clk_i = 1'b0;
  logic                        rst_n_i = 1'b0;
  logic [QUEUES*SIZE_W-1:0]    size_i = '0;
  logic [QUEUES-1:0]           size_val_i = '0;
  logic [QUEUES*QUANTUM_W-1:0] quantum_i = '0;
  logic                        grant_val_o;
  logic [IDX_W-1:0]            grant_idx_o;
  logic [SIZE_W-1:0]           grant_size_o;
  logic                        grant_rdy_i = 1'b0;
  logic [IDX_W-1:0]            stat_sel_i = '0;
  logic                        stat_clr_i = 1'b0;
  logic [31:0]                 stat_bytes_o;
  logic [31:0]                 stat_pkts_o;

  int n_checks = 0;
  int n_fail   = 0;

  drr_sched_weighted #(
    .QUEUES(QUEUES), .SIZE_W(SIZE_W), .QUANTUM_W(QUANTUM_W), .DFT_W(DFT_W)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .size_i(size_i), .size_val_i(size_val_i), .quantum_i(quantum_i),
    .grant_val_o(grant_val_o), .grant_idx_o(grant_idx_o), .grant_size_o(grant_size_o),
    .grant_rdy_i(grant_rdy_i),
    .stat_sel_i(stat_sel_i), .stat_clr_i(stat_clr_i),
    .stat_bytes_o(stat_bytes_o), .stat_pkts_o(stat_pkts_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_q(input int q, input logic v, input int sz);
    size_val_i[q]              = v;
    size_i[q*SIZE_W +: SIZE_W] = SIZE_W'(sz);
  endtask

  task automatic set_quanta(input int q0, input int q1, input int q2, input int q3);
    quantum_i = {QUANTUM_W'(q3), QUANTUM_W'(q2), QUANTUM_W'(q1), QUANTUM_W'(q0)};
  endtask

  task automatic apply_reset();
    rst_n_i     = 1'b0;
    size_val_i  = '0;
    size_i      = '0;
    quantum_i   = '0;
    grant_rdy_i = 1'b0;
    stat_clr_i  = 1'b0;
    stat_sel_i  = '0;
    tick();
    tick();
  endtask

  // next rising edge after this is edge 1 out of reset
  task automatic release_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  function automatic logic [DFT_W-1:0] dft(input int q);
    return dut.dft_q[q];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    logic [IDX_W-1:0] exp_idx;

    // ---- reset values and first grant with back-pressure ----
    apply_reset();
    check_eq("rst_val",   grant_val_o, 0);
    check_eq("rst_idx",   grant_idx_o, 0);
    check_eq("rst_size",  grant_size_o, 0);
    check_eq("rst_bytes", stat_bytes_o, 0);
    check_eq("rst_pkts",  stat_pkts_o, 0);
    set_quanta(500, 500, 500, 500);
    set_q(0, 1'b1, 300);
    release_reset();
    tick();
    check_eq("lat_e1_val", grant_val_o, 0);
    tick();
    check_eq("lat_e2_grant", {grant_val_o, grant_idx_o, grant_size_o}, {1'b1, 2'd0, 16'd300});
    check_eq("lat_e2_dft0", dft(0), 500);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_hold", {grant_val_o, grant_idx_o, grant_size_o, dft(0)},
               {1'b1, 2'd0, 16'd300, 20'd500});
    end
    grant_rdy_i = 1'b1;
    tick();
    grant_rdy_i = 1'b0;
    check_eq("hs_val", grant_val_o, 0);
    check_eq("hs_dft0", dft(0), 200);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq("hs_no_extra", grant_val_o, 0);
      if (i == 2) check_eq("skip_keep_dft0", dft(0), 200);
    end
    tick();
    check_eq("regrant", {grant_val_o, grant_idx_o, dft(0)}, {1'b1, 2'd0, 20'd700});

    // ---- deficit carry on q1 ----
    apply_reset();
    set_quanta(500, 500, 500, 500);
    set_q(1, 1'b1, 700);
    grant_rdy_i = 1'b1;
    release_reset();
    for (int e = 1; e <= 24; e++) begin
      tick();
      check_eq("carry_val", grant_val_o, (e == 8 || e == 16) ? 1 : 0);
      if (e == 8 || e == 16)
        check_eq("carry_grant", {grant_idx_o, grant_size_o}, {2'd1, 16'd700});
      if (e == 3)  check_eq("carry_dft_v1", dft(1), 500);
      if (e == 9)  check_eq("carry_dft_g1", dft(1), 300);
      if (e == 17) check_eq("carry_dft_g2", dft(1), 100);
      if (e == 24) check_eq("carry_dft_v4", dft(1), 600);
    end

    // ---- weighting 1000/500/250/250, three rounds ----
    apply_reset();
    set_quanta(1000, 500, 250, 250);
    for (int q = 0; q < QUEUES; q++) set_q(q, 1'b1, 250);
    grant_rdy_i = 1'b1;
    release_reset();
    n = 0;
    cyc = 0;
    while (n < 24 && cyc < 600) begin
      if (grant_val_o) begin
        case (n % 8)
          0, 1, 2, 3: exp_idx = 2'd0;
          4, 5:       exp_idx = 2'd1;
          6:          exp_idx = 2'd2;
          default:    exp_idx = 2'd3;
        endcase
        check_eq("weight_seq", {grant_idx_o, grant_size_o}, {exp_idx, 16'd250});
        n++;
      end
      tick();
      cyc++;
    end
    grant_rdy_i = 1'b0;
    check_eq("weight_count", n, 24);

    stat_sel_i = 2'd0;
    tick();
    check_eq("stat_q0_bytes", stat_bytes_o, STATS_ON ? 3000 : 0);
    check_eq("stat_q0_pkts",  stat_pkts_o,  STATS_ON ? 12 : 0);
    stat_sel_i = 2'd1;
    tick();
    check_eq("stat_q1_bytes", stat_bytes_o, STATS_ON ? 1500 : 0);
    check_eq("stat_q1_pkts",  stat_pkts_o,  STATS_ON ? 6 : 0);
    stat_sel_i = 2'd3;
    tick();
    check_eq("stat_q3_bytes", stat_bytes_o, STATS_ON ? 750 : 0);
    check_eq("stat_q3_pkts",  stat_pkts_o,  STATS_ON ? 3 : 0);

    cyc = 0;
    while (!grant_val_o && cyc < 50) begin
      tick();
      cyc++;
    end
    check_eq("clr_grant_pending", {grant_val_o, grant_idx_o}, {1'b1, 2'd0});
    grant_rdy_i = 1'b1;
    stat_clr_i  = 1'b1;
    tick();
    grant_rdy_i = 1'b0;
    stat_clr_i  = 1'b0;
    stat_sel_i  = 2'd0;
    tick();
    check_eq("clr_q0_bytes", stat_bytes_o, 0);
    check_eq("clr_q0_pkts",  stat_pkts_o, 0);

    // ---- empty queue clears its deficit at the next VISIT ----
    apply_reset();
    set_quanta(500, 500, 500, 500);
    set_q(2, 1'b1, 300);
    grant_rdy_i = 1'b1;
    release_reset();
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 4)  check_eq("empty_grant", {grant_val_o, grant_idx_o, grant_size_o},
                            {1'b1, 2'd2, 16'd300});
      if (e == 5)  check_eq("empty_dft_hs", dft(2), 200);
      if (e == 7) begin
        check_eq("empty_dft_skip", dft(2), 200);
        set_q(2, 1'b0, 0);
      end
      if (e == 10) check_eq("empty_dft_before", dft(2), 200);
      if (e == 11) check_eq("empty_dft_clear", dft(2), 0);
    end

    // ---- zero-size packet and back-to-back spacing ----
    apply_reset();
    set_quanta(100, 0, 0, 0);
    set_q(0, 1'b1, 0);
    grant_rdy_i = 1'b1;
    release_reset();
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_eq("zero_val", grant_val_o, (e == 2 || e == 5) ? 1 : 0);
      if (e == 3) check_eq("zero_dft", dft(0), 100);
    end
    check_eq("zero_size", grant_size_o, 0);

    // ---- async reset drops a held grant without a clock edge ----
    apply_reset();
    set_quanta(500, 500, 500, 500);
    set_q(0, 1'b1, 100);
    release_reset();
    tick();
    tick();
    check_eq("arst_pre", grant_val_o, 1);
    #3;
    rst_n_i = 1'b0;
    #1;
    check_eq("arst_val", grant_val_o, 0);
    check_eq("arst_idx_size", {grant_idx_o, grant_size_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
